// File: rtl/dut_mel_accum.sv
// dut_mel_accum
//   Mel filterbank accumulator. Sums signed 32-bit products (power bin x Q1.14
//   weight) over the bins of one mel filter and emits one saturated 32-bit
//   energy per filter through a single-entry valid/ready output register.
//
// Ports
//   ap_clk         : clock, rising edge
//   ap_rst_n       : synchronous active-low reset
//   in_prod        : signed product from the multiplier
//   in_valid       : in_prod valid
//   in_last        : in_prod is the final bin of the current filter
//   in_ready       : product accepted this cycle (combinational)
//   out_data       : saturated signed filter energy
//   out_filt       : filter index of out_data
//   out_frame_last : out_filt is the last filter of the frame
//   out_sat        : out_data was clipped
//   out_valid      : output register full
//   out_ready      : downstream accepts the output
//   err_overrun    : sticky, a filter was force-closed at MAX_BINS
module dut_mel_accum #(
   parameter int NUM_FILTERS = 26,
   parameter int MAX_BINS    = 257,
   parameter int ACC_W       = 41
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic [31:0] in_prod,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_filt,
   output logic        out_frame_last,
   output logic        out_sat,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_overrun
);

   localparam int CNT_W = $clog2(MAX_BINS);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] bin_cnt_q, bin_cnt_d;
   logic [4:0]       filt_q, filt_d;
   logic [31:0]      data_q, data_d;
   logic [4:0]       ofilt_q, ofilt_d;
   logic             oflast_q, oflast_d;
   logic             osat_q, osat_d;
   logic             ovalid_q, ovalid_d;
   logic             err_q, err_d;

   logic             accept, at_max, close_w, pos_ovf, neg_ovf, filt_wrap;
   logic [ACC_W-1:0] sum;

   assign in_ready = !ovalid_q || out_ready;

   always_comb begin
      accept    = in_valid && in_ready;
      at_max    = (bin_cnt_q == CNT_W'(MAX_BINS - 1));
      close_w   = accept && (in_last || at_max);
      filt_wrap = (filt_q == 5'(NUM_FILTERS - 1));
      sum       = acc_q + {{(ACC_W-32){in_prod[31]}}, in_prod};
      // Value fits in 32 signed bits only if bits [ACC_W-1:31] are all equal.
      pos_ovf   = !sum[ACC_W-1] && (|sum[ACC_W-2:31]);
      neg_ovf   = sum[ACC_W-1] && !(&sum[ACC_W-2:31]);

      acc_d     = acc_q;
      bin_cnt_d = bin_cnt_q;
      filt_d    = filt_q;
      data_d    = data_q;
      ofilt_d   = ofilt_q;
      oflast_d  = oflast_q;
      osat_d    = osat_q;
      ovalid_d  = ovalid_q;
      err_d     = err_q;

      if (ovalid_q && out_ready) begin
         ovalid_d = 1'b0;
      end

      if (accept) begin
         if (close_w) begin
            if (pos_ovf) begin
               data_d = 32'h7FFF_FFFF;
               osat_d = 1'b1;
            end else if (neg_ovf) begin
               data_d = 32'h8000_0000;
               osat_d = 1'b1;
            end else begin
               data_d = sum[31:0];
               osat_d = 1'b0;
            end
            ofilt_d   = filt_q;
            oflast_d  = filt_wrap;
            ovalid_d  = 1'b1;
            acc_d     = '0;
            bin_cnt_d = '0;
            filt_d    = filt_wrap ? 5'd0 : filt_q + 5'd1;
            if (at_max && !in_last) begin
               err_d = 1'b1;
            end
         end else begin
            acc_d     = sum;
            bin_cnt_d = bin_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         acc_q     <= '0;
         bin_cnt_q <= '0;
         filt_q    <= '0;
         data_q    <= '0;
         ofilt_q   <= '0;
         oflast_q  <= 1'b0;
         osat_q    <= 1'b0;
         ovalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         bin_cnt_q <= bin_cnt_d;
         filt_q    <= filt_d;
         data_q    <= data_d;
         ofilt_q   <= ofilt_d;
         oflast_q  <= oflast_d;
         osat_q    <= osat_d;
         ovalid_q  <= ovalid_d;
         err_q     <= err_d;
      end
   end

   assign out_data       = data_q;
   assign out_filt       = ofilt_q;
   assign out_frame_last = oflast_q;
   assign out_sat        = osat_q;
   assign out_valid      = ovalid_q;
   assign err_overrun    = err_q;

endmodule

// File: tb/tb_dut_mel_accum.sv
module tb_dut_mel_accum;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [31:0] in_prod;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic [4:0]  out_filt;
   logic        out_frame_last;
   logic        out_sat;
   logic        out_valid;
   logic        out_ready;
   logic        err_overrun;

   dut_mel_accum #(.NUM_FILTERS(26), .MAX_BINS(257), .ACC_W(41)) u_dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .in_prod        (in_prod),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_filt       (out_filt),
      .out_frame_last (out_frame_last),
      .out_sat        (out_sat),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .err_overrun    (err_overrun)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  f;
      logic        fl;
      logic        s;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   exp_filt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Expected output for the filter whose closing product is about to be issued.
   task automatic expect_out(input logic [31:0] d, input logic s);
      exp_t e;
      e.d  = d;
      e.f  = 5'(exp_filt);
      e.fl = (exp_filt == 25);
      e.s  = s;
      sb.push_back(e);
      exp_filt = (exp_filt == 25) ? 0 : exp_filt + 1;
   endtask

   // Monitor: inputs change on the falling edge; 2 ns later everything that
   // decides the next rising-edge handshake is stable.
   always @(negedge ap_clk) begin
      exp_t e;
      #2;
      if (ap_rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data 0x%08h filt %0d, required none", out_data, out_filt);
         end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_filt", 32'(out_filt), 32'(e.f));
            chk("out_frame_last", 32'(out_frame_last), 32'(e.fl));
            chk("out_sat", 32'(out_sat), 32'(e.s));
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [31:0] prod, input logic last);
      int n;
      in_prod  = prod;
      in_last  = last;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge ap_clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 required 1");
      end
      @(negedge ap_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge ap_clk);
         n++;
      end
      @(negedge ap_clk);
      @(negedge ap_clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: pending %0d required 0", sb.size());
      end
   endtask

   task automatic do_reset();
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      sb.delete();
      exp_filt = 0;
   endtask

   task automatic chk_reset_state();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_filt", 32'(out_filt), 32'd0);
      chk("rst_out_frame_last", 32'(out_frame_last), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_err_overrun", 32'(err_overrun), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst_n  = 1'b0;
      in_prod   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      chk_reset_state();
      @(negedge ap_clk);

      // 100 + 200 - 50 + 7 = 257, one cycle latency
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      send(-32'sd50, 1'b0);
      expect_out(32'd257, 1'b0);
      in_prod = 32'd7; in_last = 1'b1; in_valid = 1'b1;
      @(negedge ap_clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      drain();

      // full frame: 26 filters x 3 bins of 1000
      do_reset();
      for (int f = 0; f < 26; f++) begin
         send(32'd1000, 1'b0);
         send(32'd1000, 1'b0);
         expect_out(32'd3000, 1'b0);
         send(32'd1000, 1'b1);
      end
      drain();

      // saturation, filters 0 and 1 of the next frame
      send(32'h7FFF_0000, 1'b0);
      expect_out(32'h7FFF_FFFF, 1'b1);
      send(32'h7FFF_0000, 1'b1);
      send(32'h8001_0000, 1'b0);
      expect_out(32'h8000_0000, 1'b1);
      send(32'h8001_0000, 1'b1);
      drain();

      // backpressure: filter 2 = 42 held for 5 cycles, filter 3 = 11 waiting
      out_ready = 1'b0;
      expect_out(32'd42, 1'b0);
      send(32'd42, 1'b1);
      in_prod = 32'd11; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_data", out_data, 32'd42);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         @(negedge ap_clk);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      expect_out(32'd11, 1'b0);
      @(negedge ap_clk);
      in_valid = 1'b0; in_last = 1'b0;
      #2;
      chk("release_reload_data", out_data, 32'd11);
      @(negedge ap_clk);
      drain();

      // forced close at 257 bins, filter 4; then filter 5 starts from zero
      for (int i = 0; i < 256; i++) send(32'd1, 1'b0);
      #1;
      chk("pre_overrun_valid", 32'(out_valid), 32'd0);
      chk("pre_overrun_err", 32'(err_overrun), 32'd0);
      @(negedge ap_clk);
      expect_out(32'd257, 1'b0);
      send(32'd1, 1'b0);
      expect_out(32'd9, 1'b0);
      send(32'd9, 1'b1);
      drain();
      chk("err_overrun_sticky", 32'(err_overrun), 32'd1);

      // reset in the middle of filter 3
      do_reset();
      expect_out(32'd1, 1'b0); send(32'd1, 1'b1);
      expect_out(32'd2, 1'b0); send(32'd2, 1'b1);
      expect_out(32'd3, 1'b0); send(32'd3, 1'b1);
      send(32'd500, 1'b0);
      send(32'd500, 1'b0);
      chk("pre_reset_pending", 32'(sb.size()), 32'd0);
      do_reset();
      chk_reset_state();
      @(negedge ap_clk);
      expect_out(32'd5, 1'b0);
      send(32'd5, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
